// File: rtl/grant_tracker.sv
// Ownership stage behind the 8-way priority selector: latches one owner until release, request drop or tenure timeout.
// Optional GT_FAIR_MASK_EN: masks a timed-out owner's request until another requester wins or nothing else is pending.
module grant_tracker #(
  parameter int N          = 8,
  parameter int IDX_W      = 3,
  parameter int MAX_TENURE = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     sel_gnt,
  input  logic             sel_req_up,
  input  logic             owner_release,
  output logic             sel_en,
  output logic             owner_valid,
  output logic [N-1:0]     owner_onehot,
  output logic [IDX_W-1:0] owner_idx,
  output logic             grant_pulse,
  output logic             timeout_pulse,
  output logic             err_multi,
  output logic [N-1:0]     req_mask
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWNED = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_valid_q, owner_valid_d;
  logic [N-1:0]     owner_onehot_q, owner_onehot_d;
  logic [IDX_W-1:0] owner_idx_q, owner_idx_d;
  logic             grant_pulse_q, grant_pulse_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic             err_multi_q, err_multi_d;

  logic [IDX_W-1:0] top_idx;
  logic [N-1:0]     top_hot;
  logic             gnt_multi;
  logic             capture;
  logic             owner_req;
  logic             tenure_done;
  logic             normal_exit;
  logic             timeout_exit;

  // A malformed multi-hot grant resolves to its highest bit, matching selector priority.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_gnt[i]) top_idx = IDX_W'(i);
    end
    top_hot = N'(1) << top_idx;
  end

  assign gnt_multi    = (sel_gnt & (sel_gnt - N'(1))) != '0;
  assign capture      = sel_req_up && (sel_gnt != '0);
  assign owner_req    = req[owner_idx_q];
  assign tenure_done  = cnt_q == CNT_W'(MAX_TENURE - 1);
  assign normal_exit  = owner_release || !owner_req;
  assign timeout_exit = (state_q == S_OWNED) && tenure_done && !normal_exit;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    owner_valid_d   = owner_valid_q;
    owner_onehot_d  = owner_onehot_q;
    owner_idx_d     = owner_idx_q;
    grant_pulse_d   = 1'b0;
    timeout_pulse_d = 1'b0;
    err_multi_d     = err_multi_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          state_d        = S_OWNED;
          cnt_d          = '0;
          owner_valid_d  = 1'b1;
          owner_onehot_d = top_hot;
          owner_idx_d    = top_idx;
          grant_pulse_d  = 1'b1;
          if (gnt_multi) err_multi_d = 1'b1;
        end
      end
      S_OWNED: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (normal_exit || tenure_done) begin
          state_d         = S_GAP;
          owner_valid_d   = 1'b0;
          owner_onehot_d  = '0;
          owner_idx_d     = '0;
          timeout_pulse_d = timeout_exit;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d        = S_IDLE;
        owner_valid_d  = 1'b0;
        owner_onehot_d = '0;
        owner_idx_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      owner_valid_q   <= 1'b0;
      owner_onehot_q  <= '0;
      owner_idx_q     <= '0;
      grant_pulse_q   <= 1'b0;
      timeout_pulse_q <= 1'b0;
      err_multi_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      owner_valid_q   <= owner_valid_d;
      owner_onehot_q  <= owner_onehot_d;
      owner_idx_q     <= owner_idx_d;
      grant_pulse_q   <= grant_pulse_d;
      timeout_pulse_q <= timeout_pulse_d;
      err_multi_q     <= err_multi_d;
    end
  end

`ifdef GT_FAIR_MASK_EN
  logic [N-1:0] req_mask_q, req_mask_d;

  // The mask lifts when someone other than the masked requester wins, or nobody else is asking.
  always_comb begin
    req_mask_d = req_mask_q;
    if (timeout_exit) begin
      req_mask_d = ~owner_onehot_q;
    end else if ((state_q == S_IDLE) &&
                 (((req & req_mask_q) == '0) || (capture && ((top_hot & ~req_mask_q) == '0)))) begin
      req_mask_d = '1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) req_mask_q <= '1;
    else          req_mask_q <= req_mask_d;
  end

  assign req_mask = req_mask_q;
`else
  assign req_mask = '1;
`endif

  assign sel_en        = state_q == S_IDLE;
  assign owner_valid   = owner_valid_q;
  assign owner_onehot  = owner_onehot_q;
  assign owner_idx     = owner_idx_q;
  assign grant_pulse   = grant_pulse_q;
  assign timeout_pulse = timeout_pulse_q;
  assign err_multi     = err_multi_q;

endmodule

// File: tb/tb_grant_tracker.sv
// Bench for grant_tracker: behavioural ownership model feeds a scoreboard queue; a negedge monitor compares.
module tb_grant_tracker;

  localparam int N = 8;
  localparam int MAX_TENURE = 16;
`ifdef GT_FAIR_MASK_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req = '0, sel_gnt = '0;
  logic       sel_req_up = 1'b0, owner_release = 1'b0;
  logic       sel_en, owner_valid, grant_pulse, timeout_pulse, err_multi;
  logic [7:0] owner_onehot, req_mask;
  logic [2:0] owner_idx;

  grant_tracker #(.N(N), .IDX_W(3), .MAX_TENURE(MAX_TENURE), .CNT_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .sel_gnt(sel_gnt),
    .sel_req_up(sel_req_up), .owner_release(owner_release), .sel_en(sel_en),
    .owner_valid(owner_valid), .owner_onehot(owner_onehot), .owner_idx(owner_idx),
    .grant_pulse(grant_pulse), .timeout_pulse(timeout_pulse), .err_multi(err_multi),
    .req_mask(req_mask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       ov;
    logic [7:0] oh;
    logic [2:0] oi;
    logic       se, gp, tp, em;
    logic [7:0] rm;
  } exp_t;

  exp_t exp_q[$];
  int   gq[$];
  int   n_cmp = 0, n_bad = 0;
  bit   in_reset = 1'b1;

  // Reference model: who owns the resource, for how long, and the pulses due this cycle.
  int         own = -1;
  int         held = 0;
  bit         in_gap = 0, gp_m = 0, tp_m = 0, err_m = 0;
  logic [7:0] mask_m = 8'hFF;
  logic [7:0] cur_req = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int hi_bit(input logic [7:0] v);
    int h = -1;
    for (int i = 0; i < 8; i++) if (v[i]) h = i;
    return h;
  endfunction

  task automatic model_reset();
    own = -1; held = 0; in_gap = 0; gp_m = 0; tp_m = 0; err_m = 0; mask_m = 8'hFF;
  endtask

  task automatic advance(input logic [7:0] r, input logic [7:0] g, input logic up, input logic rel);
    int h;
    bit cap;
    gp_m = 0;
    tp_m = 0;
    if (own >= 0) begin
      held++;
      if (rel || !r[own] || held == MAX_TENURE) begin
        tp_m = (held == MAX_TENURE) && !rel && r[own];
        if (tp_m && FAIR) mask_m = 8'hFF ^ (8'h01 << own);
        own = -1;
        in_gap = 1;
      end
    end else if (in_gap) begin
      in_gap = 0;
    end else begin
      h = hi_bit(g);
      cap = up && (g != 0);
      if (FAIR && (((r & mask_m) == 0) || (cap && mask_m[h]))) mask_m = 8'hFF;
      if (cap) begin
        own = h;
        held = 0;
        gp_m = 1;
        if ($countones(g) > 1) err_m = 1;
        gq.push_back(h);
      end
    end
  endtask

  // gmode: 0 well-formed selector, 1 up without grant, 2 corrupted multi-hot grant, 3 explicit grant
  task automatic step(input logic [7:0] r, input logic rel, input int gmode, input logic [7:0] g_explicit);
    exp_t e;
    logic [7:0] eff, g;
    logic up;
    int h;
    @(posedge clock);
    #1;
    e.ov = own >= 0;
    e.oh = (own >= 0) ? (8'h01 << own) : 8'h00;
    e.oi = (own >= 0) ? 3'(own) : 3'd0;
    e.se = (own < 0) && !in_gap;
    e.gp = gp_m;
    e.tp = tp_m;
    e.em = err_m;
    e.rm = mask_m;
    exp_q.push_back(e);
    eff = r & mask_m;
    h = hi_bit(eff);
    g = 8'h00;
    up = |eff;
    if (e.se) begin
      case (gmode)
        1: begin g = 8'h00; up = 1'b1; end
        2: if (h > 0) g = (8'h01 << h) | (8'h01 << $urandom_range(0, h - 1));
           else if (h == 0) g = 8'h01;
        3: begin g = g_explicit; up = 1'b1; end
        default: if (h >= 0) g = 8'h01 << h;
      endcase
    end
    req = r; sel_gnt = g; sel_req_up = up; owner_release = rel;
    advance(r, g, up, rel);
  endtask

  task automatic mid_reset();
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    in_reset = 1'b1;
    sel_gnt = '0; sel_req_up = 1'b0; owner_release = 1'b0;
    #1;
    chk("rst_async_owner_valid", owner_valid, 0);
    chk("rst_async_sel_en", sel_en, 1);
    chk("rst_async_onehot", owner_onehot, 0);
    chk("rst_async_err_multi", err_multi, 0);
    chk("rst_async_pulses", {grant_pulse, timeout_pulse}, 0);
    chk("rst_async_req_mask", req_mask, 8'hFF);
    exp_q.delete();
    gq.delete();
    model_reset();
    #3;
    reset_n = 1'b1;
    in_reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!in_reset) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("owner_valid", owner_valid, e.ov);
        chk("owner_onehot", owner_onehot, e.oh);
        chk("owner_idx", owner_idx, e.oi);
        chk("sel_en", sel_en, e.se);
        chk("grant_pulse", grant_pulse, e.gp);
        chk("timeout_pulse", timeout_pulse, e.tp);
        chk("err_multi", err_multi, e.em);
        chk("req_mask", req_mask, e.rm);
      end
      if (grant_pulse === 1'b1) begin
        if (gq.size() > 0) chk("grant_event_idx", owner_idx, gq.pop_front());
        else chk("grant_event_unexpected", grant_pulse, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("reset_sel_en", sel_en, 1);
    chk("reset_owner_valid", owner_valid, 0);
    chk("reset_owner_idx", owner_idx, 0);
    chk("reset_onehot", owner_onehot, 0);
    chk("reset_pulses", {grant_pulse, timeout_pulse}, 0);
    chk("reset_err_multi", err_multi, 0);
    chk("reset_req_mask", req_mask, 8'hFF);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    in_reset = 1'b0;

    // idle with no requests
    repeat (5) step(8'h00, 0, 0, 8'h00);
    // owner 5 granted, released in its 4th owned cycle, then requester 2
    step(8'h24, 0, 0, 8'h00);
    repeat (3) step(8'h24, 0, 0, 8'h00);
    step(8'h24, 1, 0, 8'h00);
    step(8'h04, 0, 0, 8'h00);
    step(8'h04, 0, 0, 8'h00);
    repeat (3) step(8'h04, 0, 0, 8'h00);
    step(8'h00, 0, 0, 8'h00);
    repeat (2) step(8'h00, 0, 0, 8'h00);
    // owner 7 holds past its tenure, then requester 3 competes
    repeat (24) step(8'h88, 0, 0, 8'h00);
    repeat (3) step(8'h08, 0, 0, 8'h00);
    repeat (3) step(8'h00, 0, 0, 8'h00);
    // up without grant stays idle, then a multi-hot grant
    repeat (2) step(8'h0A, 0, 1, 8'h00);
    step(8'h0A, 0, 3, 8'h0A);
    repeat (3) step(8'h0A, 0, 0, 8'h00);
    step(8'h02, 1, 0, 8'h00);
    repeat (4) step(8'h02, 0, 0, 8'h00);
    step(8'h00, 0, 0, 8'h00);
    repeat (2) step(8'h00, 0, 0, 8'h00);
    // owner 6 mid-tenure when reset hits, then a fresh grant
    repeat (4) step(8'h40, 0, 0, 8'h00);
    mid_reset();
    repeat (4) step(8'h11, 0, 0, 8'h00);

    cur_req = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      int gm;
      if ($urandom_range(0, 15) == 0) cur_req = 8'($urandom);
      gm = $urandom_range(0, 19);
      step(cur_req, ($urandom_range(0, 11) == 0), (gm == 0) ? 1 : (gm == 1) ? 2 : 0, 8'h00);
    end

    repeat (4) step(8'h00, 0, 0, 8'h00);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("grant_queue_drained", gq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grant_tracker.md
Name: grant_tracker

Overview:
- Sequential ownership stage directly downstream of the 8-way fixed-priority selector (ps8).
- Consumes the selector's one-hot grant and request-up, and latches a single owner.
- Holds ownership until release, request drop, or tenure timeout.
- Drives the selector's enable so re-arbitration happens only when the resource is free.

Parameters:
N, 8, number of requesters; must match selector width
IDX_W, 3, owner index width, equal to clog2(N)
MAX_TENURE, 16, maximum cycles an owner may hold; range 2..2^CNT_W
CNT_W, 5, tenure counter width

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  N  raw request vector; same vector that feeds the selector
sel_gnt  input  N  one-hot grant from the selector
sel_req_up  input  1  any-request flag from the selector
release  input  1  current owner finished; sampled only in OWNED
sel_en  output  1  enable to the selector
owner_valid  output  1  an owner currently holds the resource
owner_onehot  output  N  registered one-hot owner
owner_idx  output  IDX_W  binary index of owner
grant_pulse  output  1  one-cycle pulse on first cycle of ownership
timeout_pulse  output  1  one-cycle pulse when tenure expired
err_multi  output  1  sticky: sel_gnt observed with more than one bit set
req_mask  output  N  mask for upstream request AND-ing; all ones unless GT_FAIR_MASK_EN

Behaviour:
- States: IDLE, OWNED, GAP. The state register resets asynchronously to IDLE when reset_n=0.
- Reset values:
  - owner_valid=0, owner_onehot=0, owner_idx=0.
  - grant_pulse=0, timeout_pulse=0, err_multi=0.
  - Tenure counter=0, req_mask=all ones.
- sel_en is combinational from state: 1 in IDLE, 0 in OWNED and GAP. It is therefore 1 during reset.

IDLE:
- If sel_req_up=1 and sel_gnt!=0 at a clock edge:
  - capture owner_onehot<=sel_gnt and owner_idx<=encode(sel_gnt);
  - clear the counter and go to OWNED.
- Next cycle: owner_valid=1 and grant_pulse=1. Latency from request to owner_valid is 1 cycle.
- If sel_gnt has more than one bit set:
  - set err_multi=1;
  - capture only the highest set bit, consistent with selector priority (bit N-1 highest).
- sel_req_up=1 with sel_gnt=0: remain in IDLE, no error.

OWNED:
- owner_valid=1. The counter increments each cycle, saturating.
- Exit to GAP at the edge where any of the following holds:
  - release=1;
  - req[owner_idx]=0;
  - counter==MAX_TENURE-1.
- Timeout exit pulses timeout_pulse for 1 cycle, concurrent with the GAP cycle.
- If release or request-drop coincides with timeout, it is a normal exit: timeout_pulse=0.
- owner_onehot and owner_idx are stable throughout OWNED.

GAP:
- Exactly 1 cycle. owner_valid=0, sel_en=0.
- owner_onehot and owner_idx are cleared to 0.
- Next state is IDLE unconditionally.
- Minimum spacing between two grant_pulses is 3 cycles at MAX_TENURE≥2.

Other rules:
- release in IDLE or GAP is ignored.
- Reset asserted mid-OWNED: all outputs return to reset values immediately, without waiting for a clock. No pulses are emitted.
- err_multi is cleared only by reset.

Optional Feature:
GT_FAIR_MASK_EN
- Defined:
  - On a timeout exit, req_mask clears the bit of the timed-out owner.
  - The mask bit restores to 1 once a different requester reaches OWNED, or when no other request is pending in IDLE (req & req_mask == 0), so no requester is starved.
  - Upstream ANDs req with req_mask before the selector. This prevents a persistent high-priority requester from monopolising the resource via repeated timeouts.
- Undefined: req_mask is constant all ones and carries no state.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> sel_en=1, owner_valid=0, no pulses.
- req=8'h24, sel_gnt=8'h20, sel_req_up=1 -> next cycle owner_idx=5, owner_onehot=8'h20, grant_pulse=1 for 1 cycle, sel_en=0.
- Owner 5 held; release=1 in 4th OWNED cycle -> GAP 1 cycle; IDLE with sel_gnt=8'h04 -> owner_idx=2 two cycles after release.
- Owner 7 holds req high, no release, MAX_TENURE=16 -> timeout_pulse on cycle 16 after grant_pulse. With GT_FAIR_MASK_EN, req_mask=8'h7F until owner 3 is granted, then 8'hFF.
- sel_gnt=8'h0A in IDLE -> owner_idx=3, err_multi=1 sticky through later grants until reset_n=0.
- Mid-OWNED, reset_n pulsed low between edges -> owner_valid=0 and sel_en=1 immediately; first grant after reset_n=1 behaves as from reset.
